// File: rtl/shifter_seq_if.sv
// Request/result handshake bundle for shifter_seq.
// master drives requests and out_ready; slave (the unit) drives in_ready and results.
interface shifter_seq_if #(
   parameter int WIDTH = 16,
   parameter int SW    = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_data;
   logic [SW-1:0]    in_shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;

   modport master (
      output in_valid, in_op, in_data, in_shamt, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_op, in_data, in_shamt, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: at most STEP positions per cycle, valid/ready on both sides.
// Ports: clk, rst (sync, active-high), bus (shifter_seq_if.slave: request in, result out).
module shifter_seq #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4,
   parameter int SW    = $clog2(WIDTH)
) (
   input logic         clk,
   input logic         rst,
   shifter_seq_if.slave bus
);
   localparam int RW = SW + 1;
   localparam logic [RW-1:0] STEP_R = RW'(STEP);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRA = 3'b001;
   localparam logic [2:0] OP_ROR = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [2:0]       op;
   logic [WIDTH-1:0] data;
   logic [RW-1:0]    remaining;
   logic             err;
   logic             valid_q;

   logic [RW-1:0]    k;
   logic [WIDTH-1:0] step_data;
   logic             illegal;
   logic             accept;

   assign illegal = bus.in_op > OP_ROL;

   assign bus.in_ready = !rst &&
      (state == IDLE || (state == DONE && bus.out_ready));
   assign accept = bus.in_valid && bus.in_ready;

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data;
   assign bus.out_err   = err;

   assign k = (remaining > STEP_R) ? STEP_R : remaining;

   // One candidate per shift distance 1..STEP, selected by k;
   // k == 0 leaves data untouched.
   always_comb begin
      step_data = data;
      for (int j = 1; j <= STEP; j++) begin
         if (k == RW'(j)) begin
            case (op)
               OP_SLL: step_data = data << j;
               OP_SRL: step_data = data >> j;
               OP_SRA: step_data = WIDTH'($signed(data) >>> j);
               OP_ROR: step_data = (data >> j) | (data << (WIDTH - j));
               OP_ROL: step_data = (data << j) | (data >> (WIDTH - j));
               default: step_data = data;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op        <= '0;
         data      <= '0;
         remaining <= '0;
         err       <= 1'b0;
         valid_q   <= 1'b0;
      end else if (accept) begin
         op        <= bus.in_op;
         data      <= bus.in_data;
         err       <= illegal;
         remaining <= illegal ? '0 : {1'b0, bus.in_shamt};
         if (illegal || bus.in_shamt == '0) begin
            state   <= DONE;
            valid_q <= 1'b1;
         end else begin
            state   <= SHIFT;
            valid_q <= 1'b0;
         end
      end else begin
         unique case (state)
            IDLE: ;
            SHIFT: begin
               data      <= step_data;
               remaining <= remaining - k;
               if (remaining == k) begin
                  state   <= DONE;
                  valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_shifter_seq.sv
// Directed-vector bench for shifter_seq (WIDTH=16, STEP=4).
// Drives and samples 1 time unit after each rising edge.
module tb_shifter_seq;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   shifter_seq_if #(.WIDTH(16)) bus ();

   shifter_seq #(.WIDTH(16), .STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [15:0] d,
                       input logic [3:0] sh, output int lat);
      int w;
      bus.in_op    = op;
      bus.in_data  = d;
      bus.in_shamt = sh;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         tick();
         w++;
      end
      if (!bus.in_ready) chk("ready_timeout", 0, 1);
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic pop;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic vec(input string tag, input logic [2:0] op,
                      input logic [15:0] d, input logic [3:0] sh,
                      input logic [15:0] exp, input logic exp_err,
                      input int exp_lat);
      int lat;
      send(op, d, sh, lat);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_data"}, bus.out_data, exp);
      chk({tag, "_err"}, bus.out_err, exp_err);
      chk({tag, "_lat"}, lat, exp_lat);
      pop();
   endtask

   initial begin
      int lat;
      int stale;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_err", bus.out_err, 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", bus.in_ready, 1);
      tick();

      vec("sll15", 3'b000, 16'h0001, 4'd15, 16'h8000, 0, 5);
      vec("srl15", 3'b011, 16'h8000, 4'd15, 16'h0001, 0, 5);
      vec("sra15", 3'b001, 16'h8000, 4'd15, 16'hFFFF, 0, 5);
      vec("sra4",  3'b001, 16'h7FF0, 4'd4,  16'h07FF, 0, 2);
      vec("sra0",  3'b001, 16'h8421, 4'd0,  16'h8421, 0, 1);
      vec("ror4",  3'b010, 16'h1234, 4'd4,  16'h4123, 0, 2);
      vec("rol4",  3'b100, 16'h1234, 4'd4,  16'h2341, 0, 2);
      vec("ror9",  3'b010, 16'h0001, 4'd9,  16'h0080, 0, 4);
      vec("rol1",  3'b100, 16'h8001, 4'd1,  16'h0003, 0, 2);

      // Backpressure: result held, new request blocked, then
      // accepted in the releasing DONE cycle.
      send(3'b000, 16'h0003, 4'd2, lat);
      chk("bp_first", bus.out_data, 16'h000C);
      bus.in_op    = 3'b000;
      bus.in_data  = 16'h00FF;
      bus.in_shamt = 4'd8;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_hold", bus.out_data, 16'h000C);
         chk("bp_in_ready", bus.in_ready, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_accept_rdy", bus.in_ready, 1);
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk("bp_data", bus.out_data, 16'hFF00);
      chk("bp_lat", lat, 3);
      pop();

      vec("illegal", 3'b111, 16'hBEEF, 4'd5, 16'hBEEF, 1, 1);
      vec("post_ill", 3'b000, 16'h0001, 4'd4, 16'h0010, 0, 2);

      // Reset during the second SHIFT cycle discards the request.
      bus.in_op    = 3'b000;
      bus.in_data  = 16'h0001;
      bus.in_shamt = 4'd12;
      bus.in_valid = 1'b1;
      chk("mid_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_ready", bus.in_ready, 0);
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", bus.in_ready, 1);
      chk("mid_rel_data", bus.out_data, 0);
      bus.out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid) stale++;
      end
      bus.out_ready = 1'b0;
      chk("mid_stale", stale, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
